// File: rtl/sensor_frame_streamer.sv
// Snapshots NUM_CH sensor channels on each DRDY_n falling edge and streams them as one NUM_CH-word frame; first word valid 3 edges after DRDY_n is sampled low.
// Words hold stable while OUT_READY is low; events arriving mid-frame are dropped and counted as overruns.
module sensor_frame_streamer #(
  parameter int NUM_CH = 13,
  parameter int CH_W   = 16,
  parameter int SEQ_W  = 8,
  parameter int OVR_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_CH*CH_W-1:0]    CH_DATA,
  input  logic                      DRDY_n,
  input  logic                      MODE,
  input  logic                      TRIG,
  input  logic                      CLR_OVR,
  input  logic                      OUT_READY,
  output logic                      OUT_VALID,
  output logic [CH_W-1:0]           OUT_DATA,
  output logic [$clog2(NUM_CH)-1:0] OUT_CH,
  output logic                      OUT_SOF,
  output logic                      OUT_EOF,
  output logic [SEQ_W-1:0]          SEQ,
  output logic                      BUSY,
  output logic                      ARMED,
  output logic                      OVERRUN,
  output logic [OVR_W-1:0]          OVR_CNT
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, h_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              armed_q, armed_d;
  logic              ovr_q, ovr_d;
  logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic [CH_W-1:0]   snap_q [NUM_CH];
  logic [CH_W-1:0]   snap_d [NUM_CH];
  logic              drdy_evt, cap, capture, drop;

  // DRDY_n is asynchronous: two sync stages, then a history flop for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      h_q  <= 1'b1;
    end else begin
      s1_q <= DRDY_n;
      s2_q <= s1_q;
      h_q  <= s2_q;
    end
  end

  always_comb begin
    drdy_evt  = h_q & ~s2_q;
    cap       = drdy_evt & (~MODE | armed_q);
    capture   = cap & (state_q == IDLE);
    drop      = cap & (state_q == SEND);
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    armed_d   = armed_q;
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    snap_d    = snap_q;

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = '0;
          seq_d   = seq_q + SEQ_W'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            snap_d[i] = CH_DATA[i*CH_W +: CH_W];
          end
        end
      end
      SEND: begin
        if (OUT_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop on the same edge as a clear leaves exactly that one drop recorded.
    if (CLR_OVR) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end
    if (drop) begin
      ovr_d = 1'b1;
      if (CLR_OVR) begin
        ovr_cnt_d = OVR_W'(1);
      end else if (!(&ovr_cnt_q)) begin
        ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
      end
    end

    // TRIG beats a simultaneous capture so back-to-back one-shots are possible.
    if (capture) armed_d = 1'b0;
    if (TRIG)    armed_d = 1'b1;
    if (!MODE)   armed_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      seq_q     <= '0;
      armed_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      armed_q   <= armed_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      snap_q    <= snap_d;
    end
  end

  assign OUT_VALID = (state_q == SEND);
  assign BUSY      = (state_q == SEND);
  assign OUT_DATA  = OUT_VALID ? snap_q[idx_q] : '0;
  assign OUT_CH    = OUT_VALID ? idx_q : '0;
  assign OUT_SOF   = OUT_VALID && (idx_q == '0);
  assign OUT_EOF   = OUT_VALID && (idx_q == LAST_IDX);
  assign SEQ       = seq_q;
  assign ARMED     = armed_q;
  assign OVERRUN   = ovr_q;
  assign OVR_CNT   = ovr_cnt_q;

endmodule

// File: tb/tb_sensor_frame_streamer.sv
// Bench for sensor_frame_streamer: randomized channel data and ready patterns checked against a frame-level model.
module tb_sensor_frame_streamer;

  localparam int NUM_CH = 13;
  localparam int CH_W   = 16;

  logic                   CLK = 1'b0;
  logic                   RESET_N;
  logic [NUM_CH*CH_W-1:0] CH_DATA;
  logic                   DRDY_n, MODE, TRIG, CLR_OVR, OUT_READY;
  logic                   OUT_VALID, OUT_SOF, OUT_EOF, BUSY, ARMED, OVERRUN;
  logic [CH_W-1:0]        OUT_DATA;
  logic [3:0]             OUT_CH;
  logic [7:0]             SEQ, OVR_CNT;

  sensor_frame_streamer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SEQ_W(8), .OVR_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CH_DATA(CH_DATA), .DRDY_n(DRDY_n), .MODE(MODE),
    .TRIG(TRIG), .CLR_OVR(CLR_OVR), .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF),
    .SEQ(SEQ), .BUSY(BUSY), .ARMED(ARMED), .OVERRUN(OVERRUN), .OVR_CNT(OVR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Record layout: {2'b0, seq, sof, eof, ch, data}
  typedef logic [31:0] rec_t;
  rec_t got_q[$];
  rec_t exp_q[$];

  // Frame-level model
  logic [7:0] m_seq;
  bit         m_armed, m_ovr;
  int         m_cnt;

  int   rdy_mode = 0;
  int   rdy_k = 0;
  int   stab_err = 0;
  bit   prev_stall = 0;
  logic [CH_W-1:0] prev_dat;
  logic [3:0]      prev_ch;

  // Transfer monitor, sampled on the falling edge
  always @(negedge CLK) begin
    if (!RESET_N) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!OUT_VALID || OUT_DATA !== prev_dat || OUT_CH !== prev_ch)) stab_err++;
      if (OUT_VALID && OUT_READY) got_q.push_back({2'b00, SEQ, OUT_SOF, OUT_EOF, OUT_CH, OUT_DATA});
      prev_stall = OUT_VALID && !OUT_READY;
      prev_dat   = OUT_DATA;
      prev_ch    = OUT_CH;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    case (rdy_mode)
      0: OUT_READY = 1'b1;
      1: begin OUT_READY = (rdy_k % 3 == 0); rdy_k++; end
      2: OUT_READY = 1'($urandom_range(0, 1));
      default: OUT_READY = 1'b0;
    endcase
  endtask

  task automatic model_reset();
    m_seq = 8'd0; m_armed = 0; m_ovr = 0; m_cnt = 0;
  endtask

  // Applies the capture/overrun rules to one DRDY event; busy says a frame is in flight.
  task automatic model_event(input bit busy, input bit clr_same);
    if (MODE == 1'b0 || m_armed) begin
      if (busy) begin
        m_ovr = 1;
        m_cnt = clr_same ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else begin
        m_seq   = m_seq + 8'd1;
        m_armed = 0;
        for (int i = 0; i < NUM_CH; i++)
          exp_q.push_back({2'b00, m_seq, (i == 0), (i == NUM_CH - 1), 4'(i), CH_DATA[i*CH_W +: CH_W]});
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) CH_DATA[i*CH_W +: CH_W] = 16'($urandom);
  endtask

  task automatic drdy_pulse(input int low_cycles);
    DRDY_n = 1'b0;
    repeat (low_cycles) tick();
    DRDY_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int c = 0; c < 400; c++) begin
      if (!BUSY) begin done = 1; break; end
      tick();
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s_idle: BUSY=%0b after 400 cycles, expected 0", tag, BUSY); end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; DRDY_n = 1'b1; MODE = 1'b0; TRIG = 1'b0; CLR_OVR = 1'b0;
    OUT_READY = 1'b1; CH_DATA = '0;
    tick(); tick();
    n_cmp++;
    if ({OUT_VALID, BUSY, OUT_SOF, OUT_EOF} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {OUT_VALID, BUSY, OUT_SOF, OUT_EOF});
    end
    n_cmp++;
    if ({OUT_DATA, OUT_CH, SEQ} !== 28'd0) begin
      n_bad++; $display("FAIL reset_data: got data=%h ch=%0d seq=%0d expected 0", OUT_DATA, OUT_CH, SEQ);
    end
    n_cmp++;
    if ({ARMED, OVERRUN, OVR_CNT} !== 10'd0) begin
      n_bad++; $display("FAIL reset_status: got armed=%0b ovr=%0b cnt=%0d expected 0", ARMED, OVERRUN, OVR_CNT);
    end
    RESET_N = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_free_run();
    int vcnt = 0;
    got_q.delete(); exp_q.delete();
    rdy_mode = 0; OUT_READY = 1'b1;
    for (int i = 0; i < NUM_CH; i++) CH_DATA[i*CH_W +: CH_W] = 16'h1000 + 16'(i);
    model_event(0, 0);
    DRDY_n = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_cmp++;
      if (OUT_VALID !== (e == 2)) begin
        n_bad++; $display("FAIL latency_edge%0d: OUT_VALID=%0b expected %0b", e, OUT_VALID, (e == 2));
      end
    end
    for (int g = 0; g < 100; g++) begin
      if (!OUT_VALID) break;
      vcnt++;
      tick();
      if (vcnt == 1) DRDY_n = 1'b1;
    end
    n_cmp++;
    if (vcnt !== NUM_CH) begin n_bad++; $display("FAIL free_run_cycles: got %0d valid cycles expected %0d", vcnt, NUM_CH); end
    repeat (10) tick();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL free_run_words: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL free_run_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete(); exp_q.delete();
    stab_err = 0;
    for (int f = 0; f < 2; f++) begin
      rdy_mode = 1 + f; rdy_k = 0;
      rand_data();
      model_event(0, 0);
      drdy_pulse(3);
      CH_DATA = {NUM_CH{16'hFFFF}};
      wait_idle("backpressure");
      tick();
    end
    n_cmp++;
    if (stab_err !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d unstable stalls expected 0", stab_err); end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL backpressure_words: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL backpressure_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_overrun();
    got_q.delete(); exp_q.delete();
    rdy_mode = 3; OUT_READY = 1'b0;
    rand_data();
    model_event(0, 0);
    drdy_pulse(4);
    tick(); tick();
    model_event(1, 0);
    drdy_pulse(1);
    n_cmp++;
    if ({OVERRUN, OVR_CNT} !== {m_ovr, 8'(m_cnt)}) begin
      n_bad++; $display("FAIL overrun_first: got ovr=%0b cnt=%0d expected %0b/%0d", OVERRUN, OVR_CNT, m_ovr, m_cnt);
    end
    n_cmp++;
    if ({OUT_VALID, OUT_CH, SEQ} !== {1'b1, 4'd0, m_seq}) begin
      n_bad++; $display("FAIL overrun_hold: got valid=%0b ch=%0d seq=%0d expected 1/0/%0d", OUT_VALID, OUT_CH, SEQ, m_seq);
    end
    rdy_mode = 0;
    wait_idle("overrun");
    CLR_OVR = 1'b1; tick(); CLR_OVR = 1'b0;
    m_ovr = 0; m_cnt = 0;
    n_cmp++;
    if ({OVERRUN, OVR_CNT} !== 9'd0) begin
      n_bad++; $display("FAIL overrun_clear: got ovr=%0b cnt=%0d expected 0/0", OVERRUN, OVR_CNT);
    end
    rdy_mode = 3; OUT_READY = 1'b0;
    rand_data();
    model_event(0, 0);
    drdy_pulse(2);
    for (int k = 0; k < 300; k++) begin
      model_event(1, 0);
      drdy_pulse(1);
    end
    n_cmp++;
    if ({OVERRUN, OVR_CNT} !== {m_ovr, 8'(m_cnt)}) begin
      n_bad++; $display("FAIL overrun_saturate: got ovr=%0b cnt=%0d expected %0b/%0d", OVERRUN, OVR_CNT, m_ovr, m_cnt);
    end
    model_event(1, 1);
    DRDY_n = 1'b0;
    tick(); tick();
    CLR_OVR = 1'b1; tick(); CLR_OVR = 1'b0;
    DRDY_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({OVERRUN, OVR_CNT} !== {m_ovr, 8'(m_cnt)}) begin
      n_bad++; $display("FAIL overrun_clr_collide: got ovr=%0b cnt=%0d expected %0b/%0d", OVERRUN, OVR_CNT, m_ovr, m_cnt);
    end
    rdy_mode = 0;
    wait_idle("overrun2");
    tick();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL overrun_words: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL overrun_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    CLR_OVR = 1'b1; tick(); CLR_OVR = 1'b0;
    m_ovr = 0; m_cnt = 0;
  endtask

  task automatic test_one_shot();
    got_q.delete(); exp_q.delete();
    rdy_mode = 0; MODE = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      rand_data(); model_event(0, 0); drdy_pulse(2);
    end
    repeat (5) tick();
    n_cmp++;
    if ({got_q.size() == 0, ARMED, OVERRUN} !== 3'b100) begin
      n_bad++; $display("FAIL oneshot_unarmed: got words=%0d armed=%0b ovr=%0b expected 0/0/0", got_q.size(), ARMED, OVERRUN);
    end
    TRIG = 1'b1; tick(); TRIG = 1'b0; m_armed = 1;
    n_cmp++;
    if (ARMED !== m_armed) begin n_bad++; $display("FAIL oneshot_arm: got ARMED=%0b expected %0b", ARMED, m_armed); end
    for (int k = 0; k < 2; k++) begin
      rand_data(); model_event(0, 0); drdy_pulse(2);
      n_cmp++;
      if (ARMED !== m_armed) begin n_bad++; $display("FAIL oneshot_disarm%0d: got ARMED=%0b expected %0b", k, ARMED, m_armed); end
      wait_idle("oneshot");
    end
    TRIG = 1'b1; tick(); TRIG = 1'b0; m_armed = 1;
    rand_data(); model_event(0, 0);
    DRDY_n = 1'b0;
    tick(); tick();
    TRIG = 1'b1; tick(); TRIG = 1'b0; m_armed = 1;
    DRDY_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (ARMED !== m_armed) begin n_bad++; $display("FAIL oneshot_trig_collide: got ARMED=%0b expected %0b", ARMED, m_armed); end
    wait_idle("oneshot_rearm");
    rand_data(); model_event(0, 0); drdy_pulse(2);
    wait_idle("oneshot_second");
    tick();
    n_cmp++;
    if ({ARMED, OVERRUN} !== {m_armed, m_ovr}) begin
      n_bad++; $display("FAIL oneshot_status: got armed=%0b ovr=%0b expected %0b/%0b", ARMED, OVERRUN, m_armed, m_ovr);
    end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL oneshot_words: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL oneshot_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    MODE = 1'b0;
    tick();
  endtask

  task automatic test_seq_wrap();
    do_reset();
    rdy_mode = 0;
    for (int f = 0; f < 256; f++) begin
      got_q.delete(); exp_q.delete();
      model_event(0, 0);
      drdy_pulse(1);
      n_cmp++;
      if (SEQ !== m_seq) begin n_bad++; $display("FAIL seq_frame%0d: got SEQ=%0d expected %0d", f, SEQ, m_seq); end
      wait_idle("seq");
    end
    n_cmp++;
    if (SEQ !== 8'd0) begin n_bad++; $display("FAIL seq_wrap: got SEQ=%0d expected 0", SEQ); end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    got_q.delete(); exp_q.delete();
    rdy_mode = 0;
    rand_data(); model_event(0, 0); drdy_pulse(2);
    for (int c = 0; c < 50; c++) begin
      if (OUT_CH == 4'd6) begin hit = 1; break; end
      tick();
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL areset_reach_word6: OUT_CH=%0d expected 6", OUT_CH); end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({OUT_VALID, BUSY, OUT_SOF, OUT_EOF, OUT_DATA, OUT_CH, SEQ} !== 32'd0) begin
      n_bad++; $display("FAIL areset_outputs: got valid=%0b busy=%0b data=%h ch=%0d seq=%0d expected 0", OUT_VALID, BUSY, OUT_DATA, OUT_CH, SEQ);
    end
    tick();
    RESET_N = 1'b1;
    model_reset();
    tick();
    got_q.delete(); exp_q.delete();
    rand_data(); model_event(0, 0); drdy_pulse(2);
    wait_idle("areset");
    tick();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL areset_words: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL areset_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_backpressure();
    test_overrun();
    test_one_shot();
    test_seq_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
